// File: rtl/usb_cmd_rx_if.sv
// usb_cmd_rx_if -- FT245 receive-side bus bundle for usb_cmd_rx.
//
// Signals:
//   RXF      FT245 receive-FIFO-not-empty, active low (FT245 -> rx)
//   USBX     FT245 data bus, read-only view (FT245 -> rx)
//   RD_EN    bus grant from the transmit side; 0 blocks new strobes
//   RD       FT245 read strobe, active low (rx -> FT245)
//   CMD      last accepted mode code
//   CMD_STB  one-cycle pulse when CMD is written
//   TRANSLEN transfer length in bytes
//   LEN_LOAD one-cycle pulse when TRANSLEN is loaded
//   LLD      lower-level-discriminator threshold (10-bit ADC scale)
//   BUSY     high from strobe start until decode completes
//   ERR_CNT  saturating count of unrecognised command bytes
//
// Modports: slave = usb_cmd_rx itself, master = FT245 pins plus the
// downstream sequencer that consumes the decoded outputs.
interface usb_cmd_rx_if;
  logic       RXF;
  logic [7:0] USBX;
  logic       RD_EN;
  logic       RD;
  logic [7:0] CMD;
  logic       CMD_STB;
  logic [7:0] TRANSLEN;
  logic       LEN_LOAD;
  logic [9:0] LLD;
  logic       BUSY;
  logic [7:0] ERR_CNT;

  modport slave (
    input  RXF, USBX, RD_EN,
    output RD, CMD, CMD_STB, TRANSLEN, LEN_LOAD, LLD, BUSY, ERR_CNT
  );

  modport master (
    output RXF, USBX, RD_EN,
    input  RD, CMD, CMD_STB, TRANSLEN, LEN_LOAD, LLD, BUSY, ERR_CNT
  );
endinterface

// File: rtl/usb_cmd_rx.sv
// usb_cmd_rx -- FT245 receive-side command front-end.
//
// Runs the FT245 read handshake (RXF/RD), captures one command byte per
// strobe and decodes it into a mode code (CMD/CMD_STB), a transfer-length
// load (TRANSLEN/LEN_LOAD) and a saturating LLD threshold. Unknown bytes
// only bump ERR_CNT (saturating at 255).
//
// Ports:
//   CLK   125 MHz system clock
//   RSTN  synchronous active-low reset
//   bus   usb_cmd_rx_if.slave (RXF, USBX, RD_EN in; RD, CMD, CMD_STB,
//         TRANSLEN, LEN_LOAD, LLD, BUSY, ERR_CNT out)
//
// Build option:
//   USB_RX_SYNC_EN  when defined, RXF passes through a 2-flop synchroniser
//                   (reset to 1) before the IDLE decision; otherwise RXF is
//                   used directly (board-synchronous FT245 timing).
//
// Every output is a flop; there is no combinational input-to-output path.
module usb_cmd_rx #(
  parameter int         RD_LOW_CYC = 5,
  parameter int         RD_GAP_CYC = 2,
  parameter logic [9:0] LLD_INIT   = 10'd540,
  parameter logic [9:0] LLD_MAX    = 10'd1023
) (
  input logic         CLK,
  input logic         RSTN,
  usb_cmd_rx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STROBE, GAP, DECODE} state_t;

  localparam logic [7:0] LOW_LAST = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] GAP_LAST = 8'(RD_GAP_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rxf_eff;
  logic       rd_q, busy_q;
  logic [7:0] byte_p0;
  logic       vld_p0;
  logic [7:0] cmd_p1, translen_p1, err_cnt_p1;
  logic       cmd_stb_p1, len_load_p1;
  logic [9:0] lld_p1;

  // Step LLD by a signed delta and clamp to [0, LLD_MAX]; the extra width
  // keeps the intermediate sum from wrapping at either end.
  function automatic logic [9:0] lld_step(input logic [9:0] cur,
                                          input logic signed [11:0] delta);
    logic signed [11:0] sum;
    sum = $signed({2'b00, cur}) + delta;
    if (sum < 12'sd0)
      return 10'd0;
    else if (sum > $signed({2'b00, LLD_MAX}))
      return LLD_MAX;
    else
      return sum[9:0];
  endfunction

  function automatic logic [7:0] err_inc(input logic [7:0] cur);
    return (cur == 8'hFF) ? cur : cur + 8'd1;
  endfunction

`ifdef USB_RX_SYNC_EN
  logic rxf_s1, rxf_s2;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rxf_s1 <= 1'b1;
      rxf_s2 <= 1'b1;
    end else begin
      rxf_s1 <= bus.RXF;
      rxf_s2 <= rxf_s1;
    end
  end

  assign rxf_eff = rxf_s2;
`else
  assign rxf_eff = bus.RXF;
`endif

  // Handshake FSM: RXF/RD_EN only matter in IDLE, so a grant withdrawal or
  // RXF rising mid-byte never truncates a strobe already in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!rxf_eff && bus.RD_EN) begin
          state_d = STROBE;
          cnt_d   = '0;
        end
      end
      STROBE: begin
        if (cnt_q == LOW_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = DECODE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DECODE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RD and BUSY are registered from the next state so they move on the
  // same edge as the state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b1;
      busy_q  <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= (state_d != STROBE);
      busy_q  <= (state_d != IDLE);
      vld_p0  <= (state_d == DECODE);
    end
  end

  // ---- stage p0: byte capture on the edge where RD returns high ----
  always_ff @(posedge CLK) begin
    if (state_q == STROBE && cnt_q == LOW_LAST)
      byte_p0 <= bus.USBX;
  end

  // ---- stage p1: decode, applied on the edge ending DECODE ----
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cmd_p1      <= 8'd0;
      cmd_stb_p1  <= 1'b0;
      translen_p1 <= 8'd0;
      len_load_p1 <= 1'b0;
      lld_p1      <= LLD_INIT;
      err_cnt_p1  <= 8'd0;
    end else begin
      cmd_stb_p1  <= 1'b0;
      len_load_p1 <= 1'b0;
      if (vld_p0) begin
        case (byte_p0)
          8'd1: begin
            cmd_p1     <= 8'd1;
            cmd_stb_p1 <= 1'b1;
            lld_p1     <= LLD_INIT;
          end
          8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7: begin
            cmd_p1     <= byte_p0;
            cmd_stb_p1 <= 1'b1;
          end
          8'd8: begin
            cmd_p1      <= 8'd8;
            cmd_stb_p1  <= 1'b1;
            translen_p1 <= 8'd128;
            len_load_p1 <= 1'b1;
          end
          8'd16:   lld_p1 <= lld_step(lld_p1, 12'sd32);
          8'd17:   lld_p1 <= lld_step(lld_p1, -12'sd32);
          8'd18:   lld_p1 <= lld_step(lld_p1, 12'sd4);
          8'd19:   lld_p1 <= lld_step(lld_p1, -12'sd4);
          default: err_cnt_p1 <= err_inc(err_cnt_p1);
        endcase
      end
    end
  end

  assign bus.RD       = rd_q;
  assign bus.BUSY     = busy_q;
  assign bus.CMD      = cmd_p1;
  assign bus.CMD_STB  = cmd_stb_p1;
  assign bus.TRANSLEN = translen_p1;
  assign bus.LEN_LOAD = len_load_p1;
  assign bus.LLD      = lld_p1;
  assign bus.ERR_CNT  = err_cnt_p1;

endmodule

// File: tb/tb_usb_cmd_rx.sv
// tb_usb_cmd_rx -- directed self-checking bench for usb_cmd_rx.
`timescale 1ns/1ps
module tb_usb_cmd_rx;

`ifdef USB_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic CLK;
  logic RSTN;
  int   checks;
  int   failures;

  usb_cmd_rx_if u_if ();

  usb_cmd_rx dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (u_if)
  );

  initial CLK = 1'b0;
  always #4 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full byte transfer; returns cycles from RXF assertion to RD low.
  // Leaves the bench 1 ns after the DECODE-exit edge.
  task automatic xfer(input logic [7:0] b, input bit hold, output int waitc);
    u_if.USBX = b;
    u_if.RXF  = 1'b0;
    waitc = 0;
    while (u_if.RD !== 1'b0 && waitc < 20) begin
      step();
      waitc++;
    end
    if (u_if.RD !== 1'b0) begin
      chk("rd_fall_timeout", u_if.RD, 0);
      return;
    end
    if (!hold) u_if.RXF = 1'b1;
    repeat (4) step();
    chk("rd_low_last", u_if.RD, 0);
    step();
    chk("rd_high_after_low", u_if.RD, 1);
    step();
    step();
    chk("busy_in_decode", u_if.BUSY, 1);
    step();
    chk("busy_done", u_if.BUSY, 0);
  endtask

  initial begin
    int w;
    int rdlow;
    checks   = 0;
    failures = 0;
    RSTN       = 1'b0;
    u_if.RXF   = 1'b1;
    u_if.USBX  = 8'd0;
    u_if.RD_EN = 1'b1;
    step();
    step();
    RSTN = 1'b1;

    chk("rst_rd", u_if.RD, 1);
    chk("rst_cmd", u_if.CMD, 0);
    chk("rst_cmd_stb", u_if.CMD_STB, 0);
    chk("rst_translen", u_if.TRANSLEN, 0);
    chk("rst_len_load", u_if.LEN_LOAD, 0);
    chk("rst_lld", u_if.LLD, 540);
    chk("rst_busy", u_if.BUSY, 0);
    chk("rst_err", u_if.ERR_CNT, 0);

    // Length load command
    xfer(8'd8, 1'b0, w);
    chk("len_rd_latency", w, 1 + SYNC_LAT);
    chk("len_translen", u_if.TRANSLEN, 128);
    chk("len_load", u_if.LEN_LOAD, 1);
    chk("len_cmd", u_if.CMD, 8);
    chk("len_cmd_stb", u_if.CMD_STB, 1);
    step();
    chk("len_load_pulse_end", u_if.LEN_LOAD, 0);
    chk("len_stb_pulse_end", u_if.CMD_STB, 0);

    // Fine and coarse LLD steps
    xfer(8'd18, 1'b0, w);
    chk("lld_p4_a", u_if.LLD, 544);
    chk("lld_no_stb", u_if.CMD_STB, 0);
    xfer(8'd18, 1'b0, w);
    chk("lld_p4_b", u_if.LLD, 548);
    xfer(8'd18, 1'b0, w);
    chk("lld_p4_c", u_if.LLD, 552);
    xfer(8'd17, 1'b0, w);
    chk("lld_m32", u_if.LLD, 520);
    chk("lld_cmd_kept", u_if.CMD, 8);
    chk("lld_no_stb2", u_if.CMD_STB, 0);

    // LLD restore and saturation at both ends
    xfer(8'd1, 1'b0, w);
    chk("cmd1_lld", u_if.LLD, 540);
    chk("cmd1_cmd", u_if.CMD, 1);
    chk("cmd1_stb", u_if.CMD_STB, 1);
    for (int i = 1; i <= 20; i++) begin
      xfer(8'd16, 1'b0, w);
      if (i == 15) chk("lld_up_15", u_if.LLD, 1020);
      if (i == 16) chk("lld_up_clamp", u_if.LLD, 1023);
    end
    chk("lld_up_final", u_if.LLD, 1023);
    for (int i = 1; i <= 300; i++) begin
      xfer(8'd19, 1'b0, w);
      if (i == 255) chk("lld_dn_255", u_if.LLD, 3);
      if (i == 256) chk("lld_dn_clamp", u_if.LLD, 0);
    end
    chk("lld_dn_final", u_if.LLD, 0);
    chk("lld_err_zero", u_if.ERR_CNT, 0);

    // Back-to-back bytes with RXF held low
    xfer(8'd3, 1'b1, w);
    chk("b2b_first_latency", w, 1 + SYNC_LAT);
    chk("b2b_cmd3", u_if.CMD, 3);
    chk("b2b_stb3", u_if.CMD_STB, 1);
    xfer(8'd7, 1'b1, w);
    chk("b2b_period_7", 8 + w, 9);
    chk("b2b_cmd7", u_if.CMD, 7);
    xfer(8'h55, 1'b0, w);
    chk("b2b_period_55", 8 + w, 9);
    chk("b2b_err", u_if.ERR_CNT, 1);
    chk("b2b_cmd_kept", u_if.CMD, 7);
    chk("b2b_no_stb", u_if.CMD_STB, 0);

    // Grant withdrawn two cycles into the strobe
    u_if.USBX = 8'd2;
    u_if.RXF  = 1'b0;
    w = 0;
    while (u_if.RD !== 1'b0 && w < 20) begin
      step();
      w++;
    end
    chk("rden_rd_latency", w, 1 + SYNC_LAT);
    step();
    step();
    u_if.RD_EN = 1'b0;
    repeat (6) step();
    chk("rden_cmd", u_if.CMD, 2);
    chk("rden_stb", u_if.CMD_STB, 1);
    rdlow = 0;
    repeat (10) begin
      step();
      if (u_if.RD === 1'b0) rdlow++;
    end
    chk("rden_no_strobe", rdlow, 0);
    chk("rden_idle_busy", u_if.BUSY, 0);
    u_if.RD_EN = 1'b1;
    xfer(8'd4, 1'b0, w);
    chk("rden_resume_latency", w, 1);
    chk("rden_resume_cmd", u_if.CMD, 4);

    // Reset during the third strobe cycle
    u_if.USBX = 8'd5;
    u_if.RXF  = 1'b0;
    w = 0;
    while (u_if.RD !== 1'b0 && w < 20) begin
      step();
      w++;
    end
    chk("rst_mid_rd_latency", w, 1 + SYNC_LAT);
    step();
    step();
    RSTN = 1'b0;
    step();
    chk("rst_mid_rd", u_if.RD, 1);
    chk("rst_mid_cmd", u_if.CMD, 0);
    chk("rst_mid_translen", u_if.TRANSLEN, 0);
    chk("rst_mid_lld", u_if.LLD, 540);
    chk("rst_mid_busy", u_if.BUSY, 0);
    chk("rst_mid_err", u_if.ERR_CNT, 0);
    RSTN     = 1'b1;
    u_if.RXF = 1'b1;
    repeat (12) step();
    chk("rst_mid_discard_cmd", u_if.CMD, 0);
    chk("rst_mid_discard_busy", u_if.BUSY, 0);
    xfer(8'd6, 1'b0, w);
    chk("post_rst_latency", w, 1 + SYNC_LAT);
    chk("post_rst_cmd", u_if.CMD, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
